// File: rtl/heart_rate_meter_if.sv
// Heart-rate meter bus.
// Carries the time base, sensor pulse and enable towards the meter,
// and the beat strobe and bpm results back out.
interface heart_rate_meter_if;
  logic       time_base;
  logic       pulse_in;
  logic       enable;
  logic       beat;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       sat;

  modport master (
    output time_base, pulse_in, enable,
    input  beat, bpm, bpm_valid, sat
  );

  modport slave (
    input  time_base, pulse_in, enable,
    output beat, bpm, bpm_valid, sat
  );
endinterface

// File: rtl/heart_rate_meter.sv
// Heart-rate meter.
// The raw sensor pulse is synchronised, debounced and turned into a
// one-cycle beat strobe. Beats are counted over a window of time-base
// toggles and published as a saturated beats-per-minute value.
// The time base is only ever sampled as a data level in the clk domain.
module heart_rate_meter #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned TICKS_PER_WINDOW = 15,
  parameter int unsigned BPM_MULT         = 4
) (
  input logic              clk,
  input logic              rst_n,
  heart_rate_meter_if.slave bus
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TICK_W = $clog2(TICKS_PER_WINDOW + 1);
  localparam int unsigned PROD_W = 8 + $clog2(BPM_MULT + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_WINDOW - 1);
  localparam logic [PROD_W-1:0] MULT      = PROD_W'(BPM_MULT);
  localparam logic [PROD_W-1:0] BPM_MAX   = PROD_W'(255);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  // Time-base edge detection
  logic tb_q, tb_d;
  logic tick;

  // Pulse path
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_prev_q, db_prev_d;
  logic            rise_q, rise_d;
  logic            beat_q, beat_d;

  // Measurement window
  state_t            state_q, state_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        bpm_q, bpm_d;
  logic              bpm_valid_q, bpm_valid_d;
  logic              sat_q, sat_d;
  logic [7:0]        beat_cnt_next;
  logic [PROD_W-1:0] product;

  assign tick = (bus.time_base != tb_q);

  // Synchronise the sensor pulse, debounce it, and turn its rising edge into a delayed one-cycle beat
  always_comb begin
    tb_d      = bus.time_base;
    sync1_d   = bus.pulse_in;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_cnt_d  = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    db_prev_d = db_q;
    rise_d    = db_q & ~db_prev_q;
    beat_d    = rise_q;
  end

  // Window state machine: count beats and ticks, publish a saturated bpm when the window closes
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    bpm_d         = bpm_q;
    sat_d         = sat_q;
    bpm_valid_d   = 1'b0;
    beat_cnt_next = beat_cnt_q;
    if (beat_q && (beat_cnt_q != 8'hFF)) begin
      beat_cnt_next = beat_cnt_q + 8'd1;
    end
    product = PROD_W'(beat_cnt_next) * MULT;

    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        tick_cnt_d = '0;
        if (bus.enable && tick) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          tick_cnt_d = '0;
        end else if (tick && (tick_cnt_q == TICK_LAST)) begin
          bpm_d       = (product > BPM_MAX) ? 8'hFF : product[7:0];
          sat_d       = (product > BPM_MAX);
          bpm_valid_d = 1'b1;
          beat_cnt_d  = '0;
          tick_cnt_d  = '0;
        end else begin
          beat_cnt_d = beat_cnt_next;
          if (tick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state registers; the time-base sample keeps tracking during reset so release causes no tick
  always_ff @(posedge clk) begin
    tb_q <= tb_d;
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_cnt_q    <= '0;
      db_prev_q   <= 1'b0;
      rise_q      <= 1'b0;
      beat_q      <= 1'b0;
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      db_prev_q   <= db_prev_d;
      rise_q      <= rise_d;
      beat_q      <= beat_d;
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bpm_q       <= bpm_d;
      bpm_valid_q <= bpm_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.beat      = beat_q;
  assign bus.bpm       = bpm_q;
  assign bus.bpm_valid = bpm_valid_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_heart_rate_meter.sv
// Testbench for heart_rate_meter.
// Drives randomised pulse trains and a slow time base, and compares every
// output after every clock edge with an event-level reference model.
module tb_heart_rate_meter;

  localparam int D   = 4;
  localparam int TPW = 4;
  localparam int M   = 4;

  logic clk = 1'b0;
  logic rst_n;

  heart_rate_meter_if hrm_bus ();

  heart_rate_meter #(
    .DEBOUNCE_CYCLES (D),
    .TICKS_PER_WINDOW(TPW),
    .BPM_MULT        (M)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (hrm_bus)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int   edge_n    = 0;
  int   tb_period = 20;
  int   tb_phase  = 0;
  logic en_level  = 1'b0;

  // Reference model state
  logic       m_beat    = 1'b0;
  logic [7:0] m_bpm     = 8'd0;
  logic       m_valid   = 1'b0;
  logic       m_sat     = 1'b0;
  logic       m_prev_tb = 1'b1;
  logic       m_level   = 1'b0;
  bit         m_meas    = 1'b0;
  int         m_run     = 0;
  int         m_beats   = 0;
  int         m_ticks   = 0;
  int         beat_due[$];
  bit         pub_seen  = 1'b0;

  // One clk edge of the model: input runs of D samples flip the clean level,
  // a clean rise yields a beat D+3 edges after its first high sample, and
  // beats between window ticks are scaled and clipped at each window close.
  task automatic modelEdge();
    logic tick_now;
    logic beat_in;
    int   prod;
    edge_n++;
    tick_now  = (hrm_bus.time_base !== m_prev_tb);
    m_prev_tb = hrm_bus.time_base;
    beat_in   = m_beat;
    if (rst_n === 1'b0) begin
      m_beat  = 1'b0;
      m_bpm   = 8'd0;
      m_valid = 1'b0;
      m_sat   = 1'b0;
      m_level = 1'b0;
      m_meas  = 1'b0;
      m_run   = 0;
      m_beats = 0;
      m_ticks = 0;
      beat_due.delete();
    end else begin
      if (hrm_bus.pulse_in !== m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = hrm_bus.pulse_in;
          m_run   = 0;
          if (m_level) beat_due.push_back(edge_n - (D - 1) + (D + 3));
        end
      end else begin
        m_run = 0;
      end
      m_beat = 1'b0;
      if (beat_due.size() > 0 && beat_due[0] == edge_n) begin
        m_beat = 1'b1;
        void'(beat_due.pop_front());
      end
      m_valid = 1'b0;
      if (!en_level) begin
        m_meas  = 1'b0;
        m_beats = 0;
        m_ticks = 0;
      end else if (!m_meas) begin
        if (tick_now) begin
          m_meas  = 1'b1;
          m_beats = 0;
          m_ticks = 0;
        end
      end else begin
        if (beat_in && m_beats < 255) m_beats++;
        if (tick_now) begin
          m_ticks++;
          if (m_ticks == TPW) begin
            prod     = m_beats * M;
            m_bpm    = (prod > 255) ? 8'd255 : 8'(prod);
            m_sat    = (prod > 255);
            m_valid  = 1'b1;
            pub_seen = 1'b1;
            m_beats  = 0;
            m_ticks  = 0;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    total++;
    assert (hrm_bus.beat === m_beat) else begin
      bad++;
      $error("[TB] FAIL beat edge=%0d got=%0b expected=%0b", edge_n, hrm_bus.beat, m_beat);
    end
    total++;
    assert (hrm_bus.bpm === m_bpm) else begin
      bad++;
      $error("[TB] FAIL bpm edge=%0d got=%0d expected=%0d", edge_n, hrm_bus.bpm, m_bpm);
    end
    total++;
    assert (hrm_bus.bpm_valid === m_valid) else begin
      bad++;
      $error("[TB] FAIL bpm_valid edge=%0d got=%0b expected=%0b", edge_n, hrm_bus.bpm_valid, m_valid);
    end
    total++;
    assert (hrm_bus.sat === m_sat) else begin
      bad++;
      $error("[TB] FAIL sat edge=%0d got=%0b expected=%0b", edge_n, hrm_bus.sat, m_sat);
    end
  endtask

  task automatic applyStimulus(input logic p);
    hrm_bus.pulse_in = p;
    hrm_bus.enable   = en_level;
    if (tb_phase >= tb_period - 1) begin
      hrm_bus.time_base = ~hrm_bus.time_base;
      tb_phase = 0;
    end else begin
      tb_phase++;
    end
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic send_pulse(input int width, input int gap);
    for (int i = 0; i < width; i++) applyStimulus(1'b1);
    for (int i = 0; i < gap; i++) applyStimulus(1'b0);
  endtask

  task automatic send_random_pulse();
    send_pulse(int'($urandom_range(D + 2, D)), int'($urandom_range(D + 4, D + 2)));
  endtask

  task automatic wait_publish(input string tag, input int max_steps);
    int n;
    n        = 0;
    pub_seen = 1'b0;
    while (!pub_seen && n < max_steps) begin
      applyStimulus(1'b0);
      n++;
    end
    total++;
    assert (pub_seen) else begin
      bad++;
      $error("[TB] FAIL %s timeout got=no_publish expected=publish within %0d", tag, max_steps);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    hrm_bus.time_base = 1'b1;
    hrm_bus.pulse_in  = 1'b0;
    hrm_bus.enable    = 1'b0;

    $display("[TB] reset with time_base high");
    idle(5);
    rst_n    = 1'b1;
    en_level = 1'b1;

    $display("[TB] short pulse rejected, long pulse gives one beat");
    idle(4);
    send_pulse(3, 8);
    send_pulse(10, 8);
    wait_publish("first_window", 200);

    $display("[TB] five beats in one window");
    for (int i = 0; i < 5; i++) send_random_pulse();
    wait_publish("five_beats", 200);

    $display("[TB] long window, many beats, saturation");
    tb_period = 800;
    tb_phase  = 0;
    pub_seen  = 1'b0;
    for (int k = 0; k < 500 && !pub_seen; k++) send_random_pulse();
    total++;
    assert (pub_seen) else begin
      bad++;
      $error("[TB] FAIL sat_window timeout got=no_publish expected=publish");
    end
    tb_period = 20;
    tb_phase  = 0;
    wait_publish("realign", 200);
    send_pulse(5, 7);
    send_pulse(5, 7);
    wait_publish("two_beats", 200);

    $display("[TB] beat coincident with window close");
    send_pulse(5, 7);
    send_pulse(5, 7);
    send_pulse(5, 7);
    idle(35);
    send_pulse(5, 0);
    wait_publish("coincident", 100);
    wait_publish("empty_window", 200);

    $display("[TB] enable drop and mid-window reset");
    send_pulse(5, 7);
    send_pulse(5, 7);
    send_pulse(5, 7);
    wait_publish("three_beats", 200);
    send_pulse(5, 7);
    send_pulse(5, 7);
    idle(21);
    en_level = 1'b0;
    idle(10);
    en_level = 1'b1;
    send_pulse(5, 7);
    wait_publish("after_reenable", 200);
    send_pulse(5, 7);
    idle(30);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(10);
    send_random_pulse();
    wait_publish("after_reset", 200);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
